if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 82 ++++++++
 tb/tb_if_id_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with Flush > Stall > load priority and edge-detected interrupt capture.
// Optional IF_ID_IRQ_SYNC_EN adds a two-flop synchroniser on IRQ_raw; otherwise IRQ_raw is used directly.
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_in,
  input  logic [31:0] PC_plus4_in,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        IRQ_raw,
  output logic [31:0] Instruction,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] PC_plus4,
  output logic        Valid,
  output logic        IRQ
);

  localparam logic [31:0] kResetPc = 32'h8000_0000;

  logic sigS;
  logic sigD;
  logic pending;
  logic irqRise;
  logic irqAccept;

`ifdef IF_ID_IRQ_SYNC_EN
  logic irqSync1;
  logic irqSync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqSync1 <= 1'b0;
      irqSync2 <= 1'b0;
    end else begin
      irqSync1 <= IRQ_raw;
      irqSync2 <= irqSync1;
    end
  end

  assign sigS = irqSync2;
`else
  assign sigS = IRQ_raw;
`endif

  // Pipeline register: a flush always wins so a squashed slot never survives a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instruction <= 32'h0;
      PC_plus4    <= kResetPc;
      Valid       <= 1'b0;
    end else if (Flush) begin
      Instruction <= 32'h0;
      PC_plus4    <= PC_plus4_in;
      Valid       <= 1'b0;
    end else if (!Stall) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
      Instruction <= Instruction_in;
      PC_plus4    <= PC_plus4_in;
      Valid       <= 1'b1;
    end
  end

  assign OpCode = Instruction[31:26];
  assign Funct  = Instruction[5:0];

  assign irqRise   = sigS & ~sigD;
  assign IRQ       = pending & Valid & ~PC_plus4[31];
  assign irqAccept = IRQ & ~Stall;

  // A rise seen on the acceptance edge re-arms pending (set wins over clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sigD    <= 1'b0;
      pending <= 1'b0;
    end else begin
      sigD    <= sigS;
      pending <= irqRise | (pending & ~irqAccept);
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage; IRQ latency follows IF_ID_IRQ_SYNC_EN if defined.
module tb_if_id_stage;

`ifdef IF_ID_IRQ_SYNC_EN
  localparam int SyncEdges = 3;
`else
  localparam int SyncEdges = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instruction_in = 32'h0;
  logic [31:0] PC_plus4_in = 32'h0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        IRQ_raw = 1'b0;
  logic [31:0] Instruction;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] PC_plus4;
  logic        Valid;
  logic        IRQ;

  int nChecks = 0;
  int nErrors = 0;

  if_id_stage dut (
    .clk           (clk),
    .reset         (reset),
    .Instruction_in(Instruction_in),
    .PC_plus4_in   (PC_plus4_in),
    .Stall         (Stall),
    .Flush         (Flush),
    .IRQ_raw       (IRQ_raw),
    .Instruction   (Instruction),
    .OpCode        (OpCode),
    .Funct         (Funct),
    .PC_plus4      (PC_plus4),
    .Valid         (Valid),
    .IRQ           (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    step(2);
    check("rst_instr", Instruction, 32'h0);
    check("rst_opcode", {26'h0, OpCode}, 32'h0);
    check("rst_funct", {26'h0, Funct}, 32'h0);
    check("rst_pc", PC_plus4, 32'h8000_0000);
    check("rst_valid", {31'h0, Valid}, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);

    // Basic load
    reset = 1'b1;
    Instruction_in = 32'h2008_0005;
    PC_plus4_in = 32'h0000_0004;
    step();
    check("load_instr", Instruction, 32'h2008_0005);
    check("load_opcode", {26'h0, OpCode}, 32'h8);
    check("load_funct", {26'h0, Funct}, 32'h5);
    check("load_pc", PC_plus4, 32'h4);
    check("load_valid", {31'h0, Valid}, 32'h1);

    // Stall freezes outputs while inputs move
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Instruction_in = 32'h1234_0000 + i;
      PC_plus4_in = 32'h0000_0100 + i;
      step();
      check("stall_instr", Instruction, 32'h2008_0005);
      check("stall_pc", PC_plus4, 32'h4);
      check("stall_valid", {31'h0, Valid}, 32'h1);
    end

    // Flush beats stall
    Flush = 1'b1;
    PC_plus4_in = 32'h0000_0008;
    step();
    check("flush_instr", Instruction, 32'h0);
    check("flush_valid", {31'h0, Valid}, 32'h0);
    check("flush_pc", PC_plus4, 32'h8);
    Flush = 1'b0;
    Stall = 1'b0;

    // User-mode interrupt: raise, accept, no repeat while held
    Instruction_in = 32'h0000_0020;
    PC_plus4_in = 32'h0000_0100;
    step();
    check("user_funct", {26'h0, Funct}, 32'h20);
    IRQ_raw = 1'b1;
    for (int i = 0; i < SyncEdges - 1; i++) begin
      step();
      check("irq_sync_wait", {31'h0, IRQ}, 32'h0);
    end
    step();
    check("irq_raise", {31'h0, IRQ}, 32'h1);
    step();
    check("irq_accepted", {31'h0, IRQ}, 32'h0);
    step(3);
    check("irq_held_once", {31'h0, IRQ}, 32'h0);

    // Kernel mode masks the pending request
    IRQ_raw = 1'b0;
    step(3);
    PC_plus4_in = 32'h8000_0040;
    step();
    IRQ_raw = 1'b1;
    step(SyncEdges);
    check("kernel_mask", {31'h0, IRQ}, 32'h0);
    step();
    check("kernel_mask2", {31'h0, IRQ}, 32'h0);
    PC_plus4_in = 32'h0000_0104;
    step();
    check("user_unmask", {31'h0, IRQ}, 32'h1);

    // Stall holds pending; flush under stall hides then restores it
    Stall = 1'b1;
    step();
    check("stall_irq1", {31'h0, IRQ}, 32'h1);
    step();
    check("stall_irq2", {31'h0, IRQ}, 32'h1);
    Flush = 1'b1;
    step();
    check("flush_irq", {31'h0, IRQ}, 32'h0);
    check("flush_valid2", {31'h0, Valid}, 32'h0);
    Flush = 1'b0;
    Stall = 1'b0;
    step();
    check("flush_persist", {31'h0, IRQ}, 32'h1);

    // Re-pulse landing on the acceptance edge keeps pending set
    Stall = 1'b1;
    IRQ_raw = 1'b0;
    step(SyncEdges);
    check("repulse_hold", {31'h0, IRQ}, 32'h1);
    IRQ_raw = 1'b1;
    step(SyncEdges - 1);
    Stall = 1'b0;
    step();
    check("repulse_set_wins", {31'h0, IRQ}, 32'h1);
    step();
    check("repulse_cleared", {31'h0, IRQ}, 32'h0);

    // Asynchronous reset with pending and valid
    IRQ_raw = 1'b0;
    step(3);
    IRQ_raw = 1'b1;
    step(SyncEdges);
    check("pre_reset_irq", {31'h0, IRQ}, 32'h1);
    #3 reset = 1'b0;
    #1;
    check("areset_irq", {31'h0, IRQ}, 32'h0);
    check("areset_valid", {31'h0, Valid}, 32'h0);
    check("areset_instr", Instruction, 32'h0);
    check("areset_pc", PC_plus4, 32'h8000_0000);
    IRQ_raw = 1'b0;
    #2 reset = 1'b1;
    Instruction_in = 32'h0123_4567;
    PC_plus4_in = 32'h0000_0200;
    step();
    check("post_reset_instr", Instruction, 32'h0123_4567);
    check("post_reset_valid", {31'h0, Valid}, 32'h1);
    check("post_reset_irq", {31'h0, IRQ}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrors);
    $finish;
  end

endmodule
